// File: rtl/line_tap_reader.sv
// ---------------------------------------------------------------------------
// line_tap_reader
//   Front end of the 3x3 image filter. It drives the two external line
//   memories with a read-before-write at the current column on every accepted
//   pixel, and registers one vertical 3-pixel column per accepted pixel.
//   Memory 0 holds the previous line; memory 1 holds the line before that.
//   The block also tracks the x/y position in the frame, flags columns whose
//   upper taps hold real frame data, and marks the end of the frame.
//
// Ports
//   clk, rstn           clock; asynchronous active-low reset
//   i_sof               start-of-frame, with or before the first pixel
//   i_valid, i_data     input pixel stream (bubbles allowed)
//   o_mem_en            write enable to both line memories (= accept)
//   o_mem_addr          shared line-memory address (0 on i_sof, else x)
//   o_mem_wdata0/1      write data: new pixel -> mem0, mem0 read -> mem1
//   i_mem_rdata0/1      combinational read data (old contents)
//   o_valid             column valid, one cycle after accept
//   o_top/o_mid/o_bot   taps from lines y-2, y-1, y
//   o_x, o_y            position of the output column
//   o_rows_ok           o_y >= 2, so all three taps are real frame data
//   o_eof               pulse with the last column of the frame
//   o_err               pulse when i_sof arrives mid-frame
// ---------------------------------------------------------------------------
module line_tap_reader #(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080,
  parameter int DW     = 8,
  parameter int AW     = 11,
  parameter int YW     = 11
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_sof,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_mem_en,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata0,
  output logic [DW-1:0] o_mem_wdata1,
  input  logic [DW-1:0] i_mem_rdata0,
  input  logic [DW-1:0] i_mem_rdata1,
  output logic          o_valid,
  output logic [DW-1:0] o_top,
  output logic [DW-1:0] o_mid,
  output logic [DW-1:0] o_bot,
  output logic [AW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_rows_ok,
  output logic          o_eof,
  output logic          o_err
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [AW-1:0] X_LAST = AW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  state_t        state, state_nxt;
  logic [AW-1:0] x, x_nxt;
  logic [YW-1:0] y, y_nxt;

  logic          accept;
  logic [AW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic          last_pix;
  logic          sof_err;

  // i_sof forces the pixel it accompanies to (0,0), so all position
  // decisions below use pos_x/pos_y rather than the raw counters.
  assign accept   = i_valid && (state == ACTIVE || i_sof);
  assign pos_x    = i_sof ? '0 : x;
  assign pos_y    = i_sof ? '0 : y;
  assign last_pix = accept && (pos_x == X_LAST) && (pos_y == Y_LAST);
  assign sof_err  = i_sof && (state == ACTIVE) && (x != '0 || y != '0);

  // Read-before-write: the memories return old contents combinationally and
  // write on the edge, so mem0's old word shifts down into mem1.
  assign o_mem_en     = accept;
  assign o_mem_addr   = pos_x;
  assign o_mem_wdata0 = i_data;
  assign o_mem_wdata1 = i_mem_rdata0;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    if (last_pix)   state_nxt = IDLE;
    else if (i_sof) state_nxt = ACTIVE;
  end

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (accept) begin
      if (pos_x == X_LAST) begin
        x_nxt = '0;
        y_nxt = (pos_y == Y_LAST) ? '0 : pos_y + YW'(1);
      end else begin
        x_nxt = pos_x + AW'(1);
        y_nxt = pos_y;
      end
    end else if (i_sof) begin
      x_nxt = '0;
      y_nxt = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
    end
  end

  // Column register: pulses clear when idle; data and position hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid   <= 1'b0;
      o_eof     <= 1'b0;
      o_err     <= 1'b0;
      o_top     <= '0;
      o_mid     <= '0;
      o_bot     <= '0;
      o_x       <= '0;
      o_y       <= '0;
      o_rows_ok <= 1'b0;
    end else begin
      o_valid <= accept;
      o_eof   <= last_pix;
      o_err   <= sof_err;
      if (accept) begin
        o_bot     <= i_data;
        o_mid     <= i_mem_rdata0;
        o_top     <= i_mem_rdata1;
        o_x       <= pos_x;
        o_y       <= pos_y;
        o_rows_ok <= (pos_y >= Y_TWO);
      end
    end
  end

endmodule

// File: tb/tb_line_tap_reader.sv
// ---------------------------------------------------------------------------
// tb_line_tap_reader
//   Bench for line_tap_reader with a 4x3 frame. Two behavioural line
//   memories sit on the DUT memory port. The reference model tracks the frame
//   as a flat pixel index (x = idx % W, y = idx / W) and keeps, per column,
//   the last two pixels ever written there, which is what the taps must show.
// ---------------------------------------------------------------------------
module tb_line_tap_reader;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int YW = 2;
  localparam int OVW = 4 + AW + YW + 3 * DW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_sof, i_valid;
  logic [DW-1:0] i_data;
  logic          o_mem_en;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata0, o_mem_wdata1;
  logic [DW-1:0] i_mem_rdata0, i_mem_rdata1;
  logic          o_valid, o_rows_ok, o_eof, o_err;
  logic [DW-1:0] o_top, o_mid, o_bot;
  logic [AW-1:0] o_x;
  logic [YW-1:0] o_y;

  always #5 clk = ~clk;

  line_tap_reader #(.WIDTH(W), .HEIGHT(H), .DW(DW), .AW(AW), .YW(YW)) dut (
    .clk(clk), .rstn(rstn), .i_sof(i_sof), .i_valid(i_valid), .i_data(i_data),
    .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr),
    .o_mem_wdata0(o_mem_wdata0), .o_mem_wdata1(o_mem_wdata1),
    .i_mem_rdata0(i_mem_rdata0), .i_mem_rdata1(i_mem_rdata1),
    .o_valid(o_valid), .o_top(o_top), .o_mid(o_mid), .o_bot(o_bot),
    .o_x(o_x), .o_y(o_y), .o_rows_ok(o_rows_ok), .o_eof(o_eof), .o_err(o_err)
  );

  // External line memories: combinational read, write on the edge.
  logic [DW-1:0] mem0 [W] = '{default: '0};
  logic [DW-1:0] mem1 [W] = '{default: '0};
  assign i_mem_rdata0 = mem0[o_mem_addr];
  assign i_mem_rdata1 = mem1[o_mem_addr];
  always @(posedge clk) begin
    if (o_mem_en) begin
      mem0[o_mem_addr] <= o_mem_wdata0;
      mem1[o_mem_addr] <= o_mem_wdata1;
    end
  end

  // Reference model state.
  int            passed = 0;
  int            total  = 0;
  int            m_idx  = 0;
  bit            m_active = 1'b0;
  logic [DW-1:0] h_last [W] = '{default: '0};
  logic [DW-1:0] h_prev [W] = '{default: '0};
  logic [DW-1:0] e_top = '0, e_mid = '0, e_bot = '0;
  int            e_x = 0, e_y = 0;
  bit            e_rows_ok = 1'b0;
  int            addr_log [$];

  task automatic model_reset();
    m_idx = 0; m_active = 1'b0;
    e_top = '0; e_mid = '0; e_bot = '0;
    e_x = 0; e_y = 0; e_rows_ok = 1'b0;
  endtask

  // Drives one cycle, checks the combinational memory port before the edge
  // and the registered column after it.
  task automatic drive_pixel(input string tag, input bit sof, input bit valid,
                             input logic [DW-1:0] data);
    bit acc, e_err, e_eof;
    int col;
    logic [1+AW+2*DW-1:0] exp_mem;
    logic [OVW-1:0] exp_out, got_out;
    @(negedge clk);
    i_sof = sof; i_valid = valid; i_data = data;
    #1;
    acc   = valid && (m_active || sof);
    e_err = sof && m_active && (m_idx != 0);
    if (sof) begin m_idx = 0; m_active = 1'b1; end
    col = m_idx % W;
    exp_mem = {acc, AW'(col), data, h_last[col]};
    total++;
    if ({o_mem_en, o_mem_addr, o_mem_wdata0, o_mem_wdata1} !== exp_mem)
      $display("FAIL %s mem_port got %h expected %h", tag,
               {o_mem_en, o_mem_addr, o_mem_wdata0, o_mem_wdata1}, exp_mem);
    else passed++;
    if (o_mem_en === 1'b1) addr_log.push_back(int'(o_mem_addr));
    e_eof = 1'b0;
    if (acc) begin
      e_bot = data; e_mid = h_last[col]; e_top = h_prev[col];
      e_x = col; e_y = m_idx / W; e_rows_ok = (e_y >= 2);
      e_eof = (m_idx == W * H - 1);
      h_prev[col] = h_last[col]; h_last[col] = data;
      m_idx++;
      if (e_eof) begin m_idx = 0; m_active = 1'b0; end
    end
    @(posedge clk); #1;
    exp_out = {acc, e_eof, e_err, e_rows_ok, AW'(e_x), YW'(e_y), e_top, e_mid, e_bot};
    got_out = {o_valid, o_eof, o_err, o_rows_ok, o_x, o_y, o_top, o_mid, o_bot};
    total++;
    if (got_out !== exp_out)
      $display("FAIL %s column {v,eof,err,ok,x,y,top,mid,bot} got %h expected %h",
               tag, got_out, exp_out);
    else passed++;
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_sof = 1'b0; i_valid = 1'b0; i_data = '0;
    #1;
    total++;
    if ({o_valid, o_eof, o_err, o_rows_ok, o_x, o_y, o_top, o_mid, o_bot} !== '0)
      $display("FAIL reset_state got %h expected 0",
               {o_valid, o_eof, o_err, o_rows_ok, o_x, o_y, o_top, o_mid, o_bot});
    else passed++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_frame();
    for (int p = 1; p <= W * H; p++) begin
      drive_pixel("frame", p == 1, 1'b1, DW'(p));
      if (p >= 9) begin
        total++;
        if (o_mid !== DW'(p - 4) || o_top !== DW'(p - 8) || o_rows_ok !== 1'b1)
          $display("FAIL frame_taps p=%0d got top=%0d mid=%0d ok=%b expected top=%0d mid=%0d ok=1",
                   p, o_top, o_mid, o_rows_ok, p - 8, p - 4);
        else passed++;
      end
      total++;
      if (o_eof !== (p == W * H))
        $display("FAIL frame_eof p=%0d got %b expected %b", p, o_eof, p == W * H);
      else passed++;
    end
  endtask

  task automatic test_bubbles();
    for (int p = 1; p <= W * H; p++) begin
      drive_pixel("bubbles_acc", p == 1, 1'b1, DW'(p));
      total++;
      if (o_x !== AW'((p - 1) % W) || o_y !== YW'((p - 1) / W))
        $display("FAIL bubbles_pos p=%0d got (%0d,%0d) expected (%0d,%0d)",
                 p, o_x, o_y, (p - 1) % W, (p - 1) / W);
      else passed++;
      drive_pixel("bubbles_gap", 1'b0, 1'b0, DW'($urandom));
    end
  endtask

  task automatic test_idle();
    logic [DW-1:0] snap0 [W];
    logic [DW-1:0] snap1 [W];
    snap0 = mem0; snap1 = mem1;
    for (int i = 0; i < 4; i++) drive_pixel("idle", 1'b0, 1'b1, DW'($urandom));
    total++;
    if (mem0 != snap0 || mem1 != snap1) $display("FAIL idle_mem memories changed got modified expected unchanged");
    else passed++;
  endtask

  task automatic test_sof_error();
    drive_pixel("err_pre", 1'b1, 1'b1, DW'($urandom));
    for (int i = 1; i < 6; i++) drive_pixel("err_pre", 1'b0, 1'b1, DW'($urandom));
    drive_pixel("err_sof", 1'b1, 1'b1, 8'hAA);
    total++;
    if (o_err !== 1'b1 || o_x !== '0 || o_y !== '0 || o_bot !== 8'hAA)
      $display("FAIL sof_err got err=%b x=%0d y=%0d bot=%h expected err=1 x=0 y=0 bot=aa",
               o_err, o_x, o_y, o_bot);
    else passed++;
    drive_pixel("err_next", 1'b0, 1'b1, DW'($urandom));
    total++;
    if (o_err !== 1'b0 || o_x !== AW'(1))
      $display("FAIL sof_err_next got err=%b x=%0d expected err=0 x=1", o_err, o_x);
    else passed++;
    for (int i = 2; i < W * H; i++)
      drive_pixel("err_tail", 1'b0, bit'($urandom_range(0, 3) != 0) || i == W * H - 1, DW'($urandom));
    while (m_active) drive_pixel("err_drain", 1'b0, 1'b1, DW'($urandom));
  endtask

  task automatic test_reset_midframe();
    drive_pixel("rst_pre", 1'b1, 1'b1, DW'($urandom));
    for (int i = 1; i < 6; i++) drive_pixel("rst_pre", 1'b0, 1'b1, DW'($urandom));
    @(negedge clk);
    i_valid = 1'b0; i_sof = 1'b0;
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({o_valid, o_eof, o_err, o_rows_ok, o_x, o_y, o_top, o_mid, o_bot} !== '0)
      $display("FAIL midframe_reset got %h expected 0",
               {o_valid, o_eof, o_err, o_rows_ok, o_x, o_y, o_top, o_mid, o_bot});
    else passed++;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) drive_pixel("rst_ignored", 1'b0, 1'b1, DW'($urandom));
    drive_pixel("rst_new", 1'b1, 1'b1, DW'($urandom));
    while (m_active) drive_pixel("rst_new", 1'b0, 1'b1, DW'($urandom));
  endtask

  task automatic test_line_boundary();
    addr_log.delete();
    for (int i = 0; i < W * H; i++) begin
      drive_pixel("line", i == 0, 1'b1, DW'($urandom));
      if (i == W) begin
        total++;
        if (o_x !== '0 || o_y !== YW'(1))
          $display("FAIL line_wrap got (%0d,%0d) expected (0,1)", o_x, o_y);
        else passed++;
      end
    end
    for (int i = 0; i < W * H; i++) begin
      total++;
      if (i >= addr_log.size() || addr_log[i] != i % W)
        $display("FAIL addr_seq[%0d] got %0d expected %0d", i,
                 (i < addr_log.size()) ? addr_log[i] : -1, i % W);
      else passed++;
    end
  endtask

  task automatic test_random();
    drive_pixel("rand", 1'b1, 1'b1, DW'($urandom));
    for (int i = 0; i < 300; i++)
      drive_pixel("rand", bit'($urandom_range(0, 29) == 0),
                  bit'($urandom_range(0, 3) != 0), DW'($urandom));
  endtask

  initial begin
    test_reset();
    test_frame();
    test_bubbles();
    test_idle();
    test_sof_error();
    test_reset_midframe();
    test_line_boundary();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/line_tap_reader.md
Name: line_tap_reader

Overview:
- Drives the two external line memories that sit in front of the 3x3 image filter, and produces one vertical 3-pixel column per input pixel.
- Each accepted pixel triggers one read-before-write on both memories at the same address:
  - memory 0 holds the previous line;
  - memory 1 holds the line before that.
- Frame-aware: tracks x/y position, flags columns whose upper taps are valid, and signals end of frame.

Parameters:
- WIDTH, 1920, pixels per line; line memory depth.
- HEIGHT, 1080, lines per frame.
- DW, 8, pixel data width.
- AW, 11, line-memory address width; must satisfy 2^AW >= WIDTH.
- YW, 11, line counter width; must satisfy 2^YW >= HEIGHT.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rstn  input  1  asynchronous active-low reset.
- i_sof  input  1  start-of-frame pulse, coincident with or before the first pixel.
- i_valid  input  1  input pixel valid.
- i_data  input  DW  input pixel.
- o_mem_en  output  1  write enable to both line memories.
- o_mem_addr  output  AW  shared address to both line memories.
- o_mem_wdata0  output  DW  write data, line memory 0.
- o_mem_wdata1  output  DW  write data, line memory 1.
- i_mem_rdata0  input  DW  combinational read data, line memory 0.
- i_mem_rdata1  input  DW  combinational read data, line memory 1.
- o_valid  output  1  column valid.
- o_top  output  DW  pixel from line y-2.
- o_mid  output  DW  pixel from line y-1.
- o_bot  output  DW  pixel from line y.
- o_x  output  AW  column index of the output.
- o_y  output  YW  line index of the output.
- o_rows_ok  output  1  high when o_y >= 2, i.e. all three taps hold real frame data.
- o_eof  output  1  one-cycle pulse with the last column of the frame.
- o_err  output  1  one-cycle pulse when i_sof arrives mid-frame.

Behaviour:
- Reset: rstn low clears, immediately and asynchronously:
  - every registered output to 0;
  - x and y counters to 0;
  - state to IDLE.
- Reset mid-frame aborts the frame; no pulse is generated.
- States: IDLE, ACTIVE.
  - IDLE: pixels with i_valid and no i_sof are ignored; o_mem_en stays 0.
  - IDLE -> ACTIVE on i_sof.
  - ACTIVE -> IDLE after accepting pixel (x=WIDTH-1, y=HEIGHT-1).
- Accept condition: i_valid and (state==ACTIVE or i_sof).
- Memory interface (combinational, same cycle as accept):
  - o_mem_en = accept.
  - o_mem_addr = 0 if i_sof, else x.
  - o_mem_wdata0 = i_data.
  - o_mem_wdata1 = i_mem_rdata0.
- The line memories read combinationally and write at the edge, so read data is the old content: previous line (memory 0) and line before (memory 1).
- With o_mem_en low, o_mem_addr still equals the current x, and wdata ports follow their sources.
- Output register, 1-cycle latency from accept:
  - o_valid = accept;
  - o_bot = i_data, o_mid = i_mem_rdata0, o_top = i_mem_rdata1;
  - o_x and o_y = position of the accepted pixel;
  - o_rows_ok = (y >= 2);
  - o_eof = last pixel of the frame.
  - When not accepting: o_valid=0, o_eof=0; data/position outputs hold their last values.
- Counters:
  - On accept, x increments.
  - At x=WIDTH-1, x wraps to 0 and y increments.
  - At the last pixel of the frame, x and y both return to 0.
- i_sof:
  - Forces the accepted pixel, if any, to position (0,0).
  - Counters continue from there: x=1 after an accompanying pixel, otherwise x=0.
  - i_sof in ACTIVE with x!=0 or y!=0 pulses o_err on the next cycle and restarts the frame.
  - i_sof in IDLE, or in ACTIVE at (0,0), is not an error.
- Memory contents are not cleared between frames. Rows y<2 carry stale data; consumers qualify with o_rows_ok.
- Gaps in i_valid (bubbles) are allowed anywhere; position state holds across them.

Test Plan:
- WIDTH=4, HEIGHT=3, rstn released; frame of pixels 1..12 with i_sof on the first -> o_valid 12 cycles each lagging 1.
  - o_bot = 1..12.
  - For pixels 9..12: o_mid = 5..8, o_top = 1..4, o_rows_ok = 1.
  - o_eof only with pixel 12 (x=3, y=2).
- Same frame with i_valid toggling every other cycle -> identical output sequence and o_x/o_y values; o_valid only on accept cycles.
- Pixels with i_valid while IDLE and no i_sof -> o_mem_en=0, o_valid=0, memories unchanged.
- i_sof asserted at x=2, y=1 with a pixel 0xAA -> o_err pulses one cycle; the output carries o_x=0, o_y=0, o_bot=0xAA; the next accept has x=1.
- rstn dropped mid-line 1 -> all outputs 0 immediately; after release, pixels are ignored until i_sof.
- Line boundary check: the pixel at x=3, y=0 is followed by o_x=0, o_y=1; o_mem_addr sequence on accepts is 0,1,2,3,0,1…
